// File: rtl/alu_arb.sv
// Two-requester round-robin front end for a shared combinational ALU, with a
// single-entry response buffer that sustains one result per cycle.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

module alu_arb (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     r0_valid,
   output logic                     r0_ready,
   input  logic [`ALU_OP_WIDTH-1:0] r0_op,
   input  logic [`CPU_WIDTH-1:0]    r0_src1,
   input  logic [`CPU_WIDTH-1:0]    r0_src2,
   input  logic                     r1_valid,
   output logic                     r1_ready,
   input  logic [`ALU_OP_WIDTH-1:0] r1_op,
   input  logic [`CPU_WIDTH-1:0]    r1_src1,
   input  logic [`CPU_WIDTH-1:0]    r1_src2,
   output logic [`ALU_OP_WIDTH-1:0] alu_op,
   output logic [`CPU_WIDTH-1:0]    alu_src1,
   output logic [`CPU_WIDTH-1:0]    alu_src2,
   input  logic [`CPU_WIDTH-1:0]    alu_res,
   input  logic                     alu_zero,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [`CPU_WIDTH-1:0]    rsp_res,
   output logic                     rsp_zero,
   output logic                     rsp_id
);

   typedef enum logic {StEmpty, StFull} state_e;

   state_e state_q, state_d;
   logic   prio_q, prio_d;
   logic   can_accept;
   logic   sel;
   logic   grant;

   always_comb begin
      can_accept = (state_q == StEmpty) | rsp_ready;
      // With both valid the pointer decides; otherwise the lone valid wins.
      if (r0_valid && r1_valid) sel = prio_q;
      else                      sel = r1_valid;
      grant = (r0_valid | r1_valid) & can_accept & ~rst;

      r0_ready = grant & ~sel;
      r1_ready = grant & sel;

      alu_op   = '0;
      alu_src1 = '0;
      alu_src2 = '0;
      if (grant) begin
         if (sel) begin
            alu_op   = r1_op;
            alu_src1 = r1_src1;
            alu_src2 = r1_src2;
         end else begin
            alu_op   = r0_op;
            alu_src1 = r0_src1;
            alu_src2 = r0_src2;
         end
      end

      state_d = state_q;
      prio_d  = prio_q;
      if (grant) begin
         state_d = StFull;
         prio_d  = ~sel;
      end else if (state_q == StFull && rsp_ready) begin
         state_d = StEmpty;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StEmpty;
         prio_q   <= 1'b0;
         rsp_res  <= '0;
         rsp_zero <= 1'b0;
         rsp_id   <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         if (grant) begin
            rsp_res  <= alu_res;
            rsp_zero <= alu_zero;
            rsp_id   <= sel;
         end
      end
   end

   assign rsp_valid = (state_q == StFull);

endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb; a small behavioural ALU closes the loop.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

module tb_alu_arb;

   localparam logic [`ALU_OP_WIDTH-1:0] AluAdd   = 1;
   localparam logic [`ALU_OP_WIDTH-1:0] AluSubNe = 5;
   localparam logic [`ALU_OP_WIDTH-1:0] AluSlt   = 8;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     r0_valid, r0_ready, r1_valid, r1_ready;
   logic [`ALU_OP_WIDTH-1:0] r0_op, r1_op, alu_op;
   logic [`CPU_WIDTH-1:0]    r0_src1, r0_src2, r1_src1, r1_src2;
   logic [`CPU_WIDTH-1:0]    alu_src1, alu_src2, alu_res, rsp_res;
   logic                     alu_zero, rsp_valid, rsp_ready, rsp_zero, rsp_id;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   alu_arb dut (
      .clk      (clk),
      .rst      (rst),
      .r0_valid (r0_valid),
      .r0_ready (r0_ready),
      .r0_op    (r0_op),
      .r0_src1  (r0_src1),
      .r0_src2  (r0_src2),
      .r1_valid (r1_valid),
      .r1_ready (r1_ready),
      .r1_op    (r1_op),
      .r1_src1  (r1_src1),
      .r1_src2  (r1_src2),
      .alu_op   (alu_op),
      .alu_src1 (alu_src1),
      .alu_src2 (alu_src2),
      .alu_res  (alu_res),
      .alu_zero (alu_zero),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_res  (rsp_res),
      .rsp_zero (rsp_zero),
      .rsp_id   (rsp_id)
   );

   // Flag meaning is op-specific: nonzero for ADD, not-equal for SUB_NE, unused for SLT.
   always_comb begin
      alu_res  = '0;
      alu_zero = 1'b0;
      unique case (alu_op)
         AluAdd: begin
            alu_res  = alu_src1 + alu_src2;
            alu_zero = |(alu_src1 + alu_src2);
         end
         AluSubNe: begin
            alu_res  = alu_src1 - alu_src2;
            alu_zero = (alu_src1 != alu_src2);
         end
         AluSlt: begin
            alu_res  = {{(`CPU_WIDTH-1){1'b0}}, ($signed(alu_src1) < $signed(alu_src2))};
            alu_zero = 1'b0;
         end
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_r0(input logic v, input logic [`ALU_OP_WIDTH-1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
      r0_valid = v; r0_op = op; r0_src1 = a; r0_src2 = b;
   endtask

   task automatic set_r1(input logic v, input logic [`ALU_OP_WIDTH-1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
      r1_valid = v; r1_op = op; r1_src1 = a; r1_src2 = b;
   endtask

   initial begin
      rst = 1'b1;
      rsp_ready = 1'b0;
      set_r0(1'b1, AluAdd, 32'd9, 32'd9);
      set_r1(1'b0, '0, '0, '0);
      #1;
      // Reset gates ready and the ALU bus even with a valid request.
      check("rst_r0_ready", {31'd0, r0_ready}, 32'd0);
      check("rst_alu_op", {28'd0, alu_op}, 32'd0);
      check("rst_alu_src1", alu_src1, 32'd0);
      step();
      step();
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_res", rsp_res, 32'd0);
      check("rst_prio", {31'd0, dut.prio_q}, 32'd0);

      // Single ADD from r0.
      rst = 1'b0;
      set_r0(1'b1, AluAdd, 32'd5, 32'd7);
      #1;
      check("add_r0_ready", {31'd0, r0_ready}, 32'd1);
      check("add_alu_op", {28'd0, alu_op}, {28'd0, AluAdd});
      check("add_alu_src2", alu_src2, 32'd7);
      step();
      r0_valid = 1'b0;
      #1;
      check("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("add_rsp_res", rsp_res, 32'd12);
      check("add_rsp_zero", {31'd0, rsp_zero}, 32'd1);
      check("add_rsp_id", {31'd0, rsp_id}, 32'd0);
      check("add_prio", {31'd0, dut.prio_q}, 32'd1);

      // Both valid every cycle: strict alternation from r0 after reset.
      rst = 1'b1;
      step();
      rst = 1'b0;
      rsp_ready = 1'b1;
      set_r0(1'b1, AluAdd, 32'd1, 32'd2);
      set_r1(1'b1, AluAdd, 32'd10, 32'd20);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("rr_r0_ready", {31'd0, r0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
         check("rr_r1_ready", {31'd0, r1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
         step();
         check("rr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         check("rr_rsp_id", {31'd0, rsp_id}, i % 2);
         check("rr_rsp_res", rsp_res, (i % 2 == 0) ? 32'd3 : 32'd30);
      end

      // Backpressure: FULL holds and r1 waits.
      r0_valid = 1'b0;
      set_r1(1'b1, AluAdd, 32'd100, 32'd1);
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_r1_ready", {31'd0, r1_ready}, 32'd0);
         step();
         check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         check("bp_rsp_res", rsp_res, 32'd30);
         check("bp_rsp_id", {31'd0, rsp_id}, 32'd1);
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_release_r1_ready", {31'd0, r1_ready}, 32'd1);
      step();
      r1_valid = 1'b0;
      #1;
      check("bp_new_res", rsp_res, 32'd101);
      check("bp_new_id", {31'd0, rsp_id}, 32'd1);
      step();
      check("drain_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("drain_rsp_res_held", rsp_res, 32'd101);

      // Op-specific zero flag and signed compare.
      set_r0(1'b1, AluSubNe, 32'd3, 32'd3);
      step();
      set_r0(1'b1, AluSlt, 32'hFFFF_FFFF, 32'd1);
      #1;
      check("subne_res", rsp_res, 32'd0);
      check("subne_zero", {31'd0, rsp_zero}, 32'd0);
      step();
      r0_valid = 1'b0;
      #1;
      check("slt_res", rsp_res, 32'd1);
      check("slt_zero", {31'd0, rsp_zero}, 32'd0);

      // Reset colliding with a grant while FULL discards everything.
      set_r0(1'b1, AluAdd, 32'd2, 32'd2);
      rst = 1'b1;
      #1;
      check("rstgrant_r0_ready", {31'd0, r0_ready}, 32'd0);
      step();
      rst = 1'b0;
      #1;
      check("rstgrant_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rstgrant_rsp_res", rsp_res, 32'd0);
      check("rstgrant_prio", {31'd0, dut.prio_q}, 32'd0);
      set_r0(1'b1, AluAdd, 32'd4, 32'd4);
      #1;
      check("post_rst_r0_ready", {31'd0, r0_ready}, 32'd1);
      step();
      r0_valid = 1'b0;
      #1;
      check("post_rst_res", rsp_res, 32'd8);
      check("post_rst_prio", {31'd0, dut.prio_q}, 32'd1);
      step();

      // Idle in EMPTY: quiet bus, pointer untouched.
      for (int i = 0; i < 10; i++) begin
         check("idle_alu_op", {28'd0, alu_op}, 32'd0);
         check("idle_alu_src1", alu_src1 | alu_src2, 32'd0);
         check("idle_readies", {30'd0, r1_ready, r0_ready}, 32'd0);
         step();
      end
      check("idle_prio", {31'd0, dut.prio_q}, 32'd1);
      check("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
- REQ-001: Widths SHALL come from defines.v macros: `CPU_WIDTH (default 32, data width), `ALU_OP_WIDTH (ALU opcode width); the block SHALL have no other parameters.
- REQ-002: Clock and reset: one clock; reset is synchronous and active-high.
- REQ-003: clk  input  1  clock; all state updates on rising edge.
- REQ-004: rst  input  1  synchronous active-high reset.
- REQ-005: r0_valid / r1_valid  input  1  requester 0/1 has an operation.
- REQ-006: r0_ready / r1_ready  output  1  requester 0/1 operation accepted this cycle.
- REQ-007: r0_op / r1_op  input  `ALU_OP_WIDTH  requested ALU operation.
- REQ-008: r0_src1, r0_src2, r1_src1, r1_src2  input  `CPU_WIDTH  operands.
- REQ-009: alu_op  output  `ALU_OP_WIDTH; alu_src1, alu_src2  output  `CPU_WIDTH; these drive the shared ALU.
- REQ-010: alu_res  input  `CPU_WIDTH; alu_zero  input  1; these are the combinational ALU results.
- REQ-011: rsp_valid  output  1  response buffer holds a result.
- REQ-012: rsp_ready  input  1  consumer takes the response.
- REQ-013: rsp_res  output  `CPU_WIDTH  registered alu_res.
- REQ-014: rsp_zero  output  1  registered alu_zero.
- REQ-015: rsp_id  output  1  requester that owns the response (0/1).

Function
- REQ-016: The block SHALL have two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1); rsp_valid SHALL equal (state==FULL).
- REQ-017: can_accept SHALL be (state==EMPTY) | rsp_ready; this is combinational.
- REQ-018: Arbitration SHALL be round-robin with a 1-bit pointer prio.
  - Only one valid: that requester is selected.
  - Both valid: requester prio is selected.
- REQ-019: rX_ready SHALL be 1 iff rX is selected and can_accept=1; at most one ready SHALL be high per cycle; ready MAY depend combinationally on valid.
- REQ-020: When a grant occurs (valid&ready), alu_op/alu_src1/alu_src2 SHALL equal the granted requester's fields that cycle; otherwise they SHALL be all zero.
- REQ-021: On a grant, at the clock edge the block SHALL:
  - load rsp_res<=alu_res, rsp_zero<=alu_zero, rsp_id<=granted index;
  - set state<=FULL;
  - set prio<=~granted index.
- REQ-022: Latency SHALL be one cycle: a request accepted in cycle N is presented with rsp_valid=1 in cycle N+1.
- REQ-023: FULL with rsp_ready=1 and no grant SHALL go to EMPTY; FULL with rsp_ready=0 SHALL hold state and all rsp_* values.
- REQ-024: FULL with rsp_ready=1 and a grant in the same cycle SHALL replace the buffer and stay FULL, giving one result per cycle throughput.
- REQ-025: prio SHALL change only on a grant; with no valid inputs, prio and state are unchanged apart from REQ-023.
- REQ-026: rsp_res, rsp_zero and rsp_id SHALL change only on a grant or on reset.
- REQ-027: A requester SHALL hold its valid and fields stable until ready; the block need not tolerate violations.

Reset
- REQ-028: While rst=1 at a clock edge, the block SHALL set state<=EMPTY, prio<=0, rsp_res<=0, rsp_zero<=0 and rsp_id<=0, overriding any same-cycle grant or rsp_ready.
- REQ-029: During rst=1, r0_ready and r1_ready SHALL be 0 and the alu_* outputs SHALL be 0.
- REQ-030: A result pending in FULL when reset asserts SHALL be discarded.

Verification
- REQ-031: Reset, then r0 `ALU_ADD src1=5 src2=7 with alu model → next cycle rsp_valid=1, rsp_res=12, rsp_zero=1, rsp_id=0, prio=1.
- REQ-032: Both valid every cycle, rsp_ready=1 → grants alternate r0,r1,r0,r1 starting with r0 after reset; one response per cycle; rsp_id alternates 0,1,0,1.
- REQ-033: FULL with rsp_ready=0 for 3 cycles and r1_valid=1 → r1_ready=0 for all 3 cycles, rsp_* stable; rsp_ready=1 → r1 granted in that cycle, its result appears next cycle.
- REQ-034: r0 `ALU_SUB_NE src1=3 src2=3 → rsp_res=0, rsp_zero=0; r0 `ALU_SLT src1=0xFFFFFFFF src2=1 → rsp_res=1, rsp_zero=0.
- REQ-035: rst=1 in the same cycle as a grant while FULL → next cycle rsp_valid=0, rsp_res=0, prio=0; the first request after reset is served normally.
- REQ-036: No valid for 10 cycles in EMPTY → alu_* = 0, readies 0, prio unchanged.
